lorenz_sample_streamer: RTL and testbench
=========================================

Name: lorenz_sample_streamer

Overview:
- Downstream consumer of the Lorenz integrator core. Every `clk` the core presents new x/y/z state in signed 7.20 fixed point.
- This block decimates that stream by a programmable divisor and rescales each sample to a narrow signed output word.
- Samples are buffered in a small synchronous FIFO and handed to a valid/ready sink (DAC/VGA plotter, UART packer).
- Samples arriving while the buffer is full are dropped and counted.

Parameters:
- N, 27, width of input state words (7.20 signed).
- OUT_W, 16, width of each output coordinate.
- SHIFT, 10, arithmetic right shift applied before narrowing to OUT_W.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DIV_W, 16, width of decimation divisor.

Ports:
- clk  in  1  system clock, shared with integrator core.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; low = no new captures, FIFO still drains.
- decim  in  DIV_W  capture one sample every decim+1 cycles.
- x_in, y_in, z_in  in  N each  integrator state outputs, 7.20 signed.
- out_valid  out  1  FIFO head holds a sample.
- out_ready  in  1  sink accepts head this cycle.
- out_x, out_y, out_z  out  OUT_W each  scaled signed coordinates at FIFO head.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- drop_flag  out  1  sticky; set on first dropped sample.
- drop_count  out  16  dropped samples, saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0, async assert, sync deassert handled upstream): div counter=0, FIFO empty, out_valid=0, out_x/y/z=0, fifo_level=0, drop_flag=0, drop_count=0.
- Decimation counter cnt:
  - enable=0: cnt forced to 0, no capture.
  - enable=1, cnt>=decim: capture this cycle, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - decim=0 captures every cycle.
  - decim changed mid-count takes effect immediately; the >= compare prevents overrun.
- First capture occurs in the cycle enable is first seen high; later captures occur every decim+1 cycles.
- Scaling, per coordinate: v = in >>> SHIFT (sign-preserving), then narrowed to OUT_W bits by dropping MSBs (see optional feature).
- FIFO is first-word-fall-through:
  - out_valid = (level != 0).
  - out_x/y/z = head entry; held stable while out_valid && !out_ready.
  - out_x/y/z = 0 when empty.
- Pop happens when out_valid && out_ready.
- Push happens on capture when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle (simultaneous push/pop at full is legal; level unchanged).
- Capture at full with no pop drops the sample: drop_flag<=1, drop_count<=drop_count+1, saturating.
- Capture and pop on an empty FIFO: no pop (out_valid=0); push proceeds and out_valid rises next cycle.
- Latency: capture at cycle t -> visible on out_x/y/z with out_valid=1 at cycle t+1 if FIFO was empty.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-stream discards all buffered samples immediately (async).

Optional Feature:
- Macro: LORENZ_STREAM_SAT_EN.
- Defined: narrowing saturates. v > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; v < -2^(OUT_W-1) -> -2^(OUT_W-1). Saturation is per coordinate.
- Not defined: plain truncation to the low OUT_W bits (wraps).

Decomposition:
- Package lorenz_pkg holds shared constants:
  - LZ_N=27, LZ_FRAC=20 (7.20 format).
  - Default OUT_W/SHIFT.
  - Packed sample width 3*OUT_W with field order {x,y,z} (x in MSBs).
- Scaling/narrowing is a function in lorenz_pkg so the integrator testbench reuses it.
- One sub-module: lorenz_stream_fifo, a generic FWFT sync FIFO with parameters (WIDTH, DEPTH), async active-low reset, push/pop/full/empty/level.

Test Plan:
- Reset then enable=1, decim=0, x_in=0x100000 (1.0), y_in=-0x280000 (-2.5), z_in=0, out_ready=1 -> next cycle out_valid=1, out_x=1024, out_y=-2560, out_z=0; one sample per cycle, level stays <=1.
- decim=3, enable=1 for 16 cycles, out_ready=1 -> exactly 4 captures, spaced 4 cycles apart; drop_count=0.
- decim=0, out_ready=0 for 12 cycles, DEPTH=8 -> level=8, drop_flag=1, drop_count=4; head data unchanged while stalled.
- FIFO full, capture plus out_ready=1 in the same cycle -> level stays 8, no drop, new sample at tail, head advances.
- x_in=40.0 (0x2800000), SHIFT=10:
  - with LORENZ_STREAM_SAT_EN -> out_x=32767;
  - without -> out_x=-24576 (0xA000);
  - x_in=-40.0 with macro -> -32768.
- Fill 5 entries, assert reset low mid-cycle -> out_valid, fifo_level, drop_count go to 0 immediately without waiting for a clk edge.

Source files
------------

// File: rtl/lorenz_pkg.sv
// rtl/lorenz_pkg.sv - shared Lorenz stream constants and the scale/narrow helper (LORENZ_STREAM_SAT_EN: saturating narrowing)
package lorenz_pkg;

    localparam int LZ_N        = 27;
    localparam int LZ_FRAC     = 20;
    localparam int LZ_OUT_W    = 16;
    localparam int LZ_SHIFT    = 10;
    localparam int LZ_SAMPLE_W = 3 * LZ_OUT_W;
    localparam int LZ_CALC_W   = 64;

    // Result is sign-extended to LZ_CALC_W; callers keep the low out_w bits.
    function automatic logic signed [LZ_CALC_W-1:0] lz_scale(
        input logic signed [LZ_CALC_W-1:0] v,
        input int                          shift,
        input int                          out_w
    );
        logic signed [LZ_CALC_W-1:0] s;
`ifdef LORENZ_STREAM_SAT_EN
        logic signed [LZ_CALC_W-1:0] hi;
        logic signed [LZ_CALC_W-1:0] lo;
        s  = v >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
`else
        s = v >>> shift;
        s = (s <<< (LZ_CALC_W - out_w)) >>> (LZ_CALC_W - out_w);
`endif
        return s;
    endfunction

endpackage

// File: rtl/lorenz_stream_fifo.sv
// rtl/lorenz_stream_fifo.sv - generic first-word-fall-through sync FIFO, async active-low reset
module lorenz_stream_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so push at full is accepted then.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      level_q <= level_q + LVL_ONE;
            else if (do_pop && !do_push) level_q <= level_q - LVL_ONE;
        end
    end

endmodule

// File: rtl/lorenz_sample_streamer.sv
// rtl/lorenz_sample_streamer.sv - decimate, rescale and buffer Lorenz x/y/z samples (LORENZ_STREAM_SAT_EN via lorenz_pkg)
module lorenz_sample_streamer
    import lorenz_pkg::*;
#(
    parameter int N     = LZ_N,
    parameter int OUT_W = LZ_OUT_W,
    parameter int SHIFT = LZ_SHIFT,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         decim,
    input  logic signed [N-1:0]      x_in,
    input  logic signed [N-1:0]      y_in,
    input  logic signed [N-1:0]      z_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_x,
    output logic signed [OUT_W-1:0]  out_y,
    output logic signed [OUT_W-1:0]  out_z,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     drop_flag,
    output logic [15:0]              drop_count
);

    localparam logic [DIV_W-1:0] CNT_ONE = 1;

    logic [DIV_W-1:0]          cnt_q, cnt_d;
    logic                      armed_q;
    logic                      drop_flag_q, drop_flag_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;
    logic                      capture, pop, full, empty, drop;
    logic signed [LZ_CALC_W-1:0] sx, sy, sz;
    logic [3*OUT_W-1:0]        wdata, rdata;
    logic                      unused_hi;

    // armed_q forces a capture on the first cycle enable is seen high.
    assign capture = enable && (!armed_q || (cnt_q >= decim));
    assign pop     = !empty && out_ready;
    assign drop    = capture && full && !pop;

    assign sx = lz_scale(LZ_CALC_W'(x_in), SHIFT, OUT_W);
    assign sy = lz_scale(LZ_CALC_W'(y_in), SHIFT, OUT_W);
    assign sz = lz_scale(LZ_CALC_W'(z_in), SHIFT, OUT_W);
    assign wdata = {sx[OUT_W-1:0], sy[OUT_W-1:0], sz[OUT_W-1:0]};
    assign unused_hi = ^{sx[LZ_CALC_W-1:OUT_W], sy[LZ_CALC_W-1:OUT_W], sz[LZ_CALC_W-1:OUT_W]};

    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        if (!enable || capture) begin
            cnt_d = '0;
        end
        drop_flag_d = drop_flag_q | drop;
        drop_cnt_d  = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            drop_flag_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            armed_q     <= enable;
            drop_flag_q <= drop_flag_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    lorenz_stream_fifo #(
        .WIDTH (3 * OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (capture),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    assign out_valid  = !empty;
    assign out_x      = rdata[3*OUT_W-1:2*OUT_W];
    assign out_y      = rdata[2*OUT_W-1:OUT_W];
    assign out_z      = rdata[OUT_W-1:0];
    assign drop_flag  = drop_flag_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_lorenz_sample_streamer.sv
// tb/tb_lorenz_sample_streamer.sv - directed self-checking bench for lorenz_sample_streamer
module tb_lorenz_sample_streamer;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [15:0]        decim;
    logic signed [26:0] x_in, y_in, z_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_x, out_y, out_z;
    logic [3:0]         fifo_level;
    logic               drop_flag;
    logic [15:0]        drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int hits[$];

    lorenz_sample_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .decim      (decim),
        .x_in       (x_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_z      (out_z),
        .fifo_level (fifo_level),
        .drop_flag  (drop_flag),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; decim = '0; out_ready = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        #12;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_flag", drop_flag, 0);
        check_eq("rst_drops", drop_count, 0);
        check_eq("rst_out_x", out_x, 0);
        reset = 1'b1;

        enable = 1'b1; decim = 16'd0; out_ready = 1'b1;
        x_in = 27'sh100000; y_in = -27'sh280000; z_in = '0;
        step();
        check_eq("d0_valid", out_valid, 1);
        check_eq("d0_out_x", out_x, 1024);
        check_eq("d0_out_y", out_y, -2560);
        check_eq("d0_out_z", out_z, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("d0_level", fifo_level, 1);
            check_eq("d0_valid_cont", out_valid, 1);
        end

        enable = 1'b0;
        step();
        check_eq("drain_level", fifo_level, 0);

        enable = 1'b1; decim = 16'd3;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (out_valid) hits.push_back(k);
        end
        check_eq("d3_captures", hits.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("d3_position", (i < hits.size()) ? hits[i] : -1, 1 + 4 * i);
        check_eq("d3_drops", drop_count, 0);

        enable = 1'b0;
        step();
        enable = 1'b1; decim = 16'd0; out_ready = 1'b0; y_in = '0;
        for (int k = 0; k < 12; k++) begin
            x_in = 27'((k + 1) << 20);
            step();
            if (k == 0) check_eq("stall_head_first", out_x, 1024);
        end
        check_eq("full_level", fifo_level, 8);
        check_eq("full_flag", drop_flag, 1);
        check_eq("full_drops", drop_count, 4);
        check_eq("stall_head_last", out_x, 1024);

        x_in = 27'(13 << 20); out_ready = 1'b1;
        step();
        check_eq("pushpop_level", fifo_level, 8);
        check_eq("pushpop_drops", drop_count, 4);
        check_eq("pushpop_head", out_x, 2048);
        enable = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check_eq("tail_level", fifo_level, 1);
        check_eq("tail_sample", out_x, 13312);
        step();
        check_eq("empty_valid", out_valid, 0);
        check_eq("empty_out_x", out_x, 0);

        enable = 1'b1; x_in = 27'sh2800000; y_in = -27'sh280000; z_in = 27'sh100000;
        step();
`ifdef LORENZ_STREAM_SAT_EN
        check_eq("sat_pos_x", out_x, 32767);
`else
        check_eq("wrap_pos_x", out_x, -24576);
`endif
        check_eq("scale_y", out_y, -2560);
        check_eq("scale_z", out_z, 1024);
        x_in = -27'sh2800000;
        step();
`ifdef LORENZ_STREAM_SAT_EN
        check_eq("sat_neg_x", out_x, -32768);
`else
        check_eq("wrap_neg_x", out_x, 24576);
`endif
        enable = 1'b0;
        step();

        out_ready = 1'b0; enable = 1'b1; x_in = 27'sh100000;
        for (int k = 0; k < 5; k++) step();
        check_eq("fill5_level", fifo_level, 5);
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_valid", out_valid, 0);
        check_eq("async_level", fifo_level, 0);
        check_eq("async_drops", drop_count, 0);
        check_eq("async_flag", drop_flag, 0);
        check_eq("async_out_x", out_x, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
